// File: rtl/delta_decoder.sv
// Delta-stream reconstructor: O[n] = O[n-1] + D[n] mod 2^WIDTH, valid/ready both sides.
// Optional signed-overflow flag O_OVF is built when DELTA_DECODER_OVF_EN is defined.
module delta_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] I,
    input  logic             I_SYNC,
    input  logic             I_VALID,
    output logic             I_READY,
    output logic [WIDTH-1:0] O,
    output logic             O_VALID,
    input  logic             O_READY,
`ifdef DELTA_DECODER_OVF_EN
    output logic             O_OVF,
`endif
    output logic             ERR
);

    typedef enum logic {
        UNSYNC = 1'b0,
        SYNC   = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] o_q;
    logic             o_valid_q;
    logic             err_q;
    logic [WIDTH-1:0] sum_d;
    logic             accept;

    // A held beat blocks input unless it drains this same cycle.
    assign I_READY = ~o_valid_q | O_READY;
    assign accept  = I_VALID & I_READY;

    // Carry-out is discarded: modulo 2^WIDTH reconstruction.
    assign sum_d = acc_q + I;

    assign O       = o_q;
    assign O_VALID = o_valid_q;
    assign ERR     = err_q;

    // Sync FSM with registered sample, valid and sticky error.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q   <= UNSYNC;
            acc_q     <= '0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (accept) begin
            unique case (state_q)
                UNSYNC: begin
                    if (I_SYNC) begin
                        acc_q     <= I;
                        o_q       <= I;
                        o_valid_q <= 1'b1;
                        state_q   <= SYNC;
                    end else begin
                        // No reference yet: delta is meaningless, drop it.
                        err_q     <= 1'b1;
                        o_valid_q <= 1'b0;
                    end
                end
                SYNC: begin
                    if (I_SYNC) begin
                        acc_q <= I;
                        o_q   <= I;
                    end else begin
                        acc_q <= sum_d;
                        o_q   <= sum_d;
                    end
                    o_valid_q <= 1'b1;
                end
                default: state_q <= UNSYNC;
            endcase
        end else if (O_READY) begin
            o_valid_q <= 1'b0;
        end
    end

`ifdef DELTA_DECODER_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Signed overflow: operands agree in sign, result disagrees.
    assign ovf_d = (acc_q[WIDTH-1] == I[WIDTH-1]) &&
                   (sum_d[WIDTH-1] != acc_q[WIDTH-1]);

    assign O_OVF = ovf_q;

    // Overflow flag travels with O; cleared on reference beats.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            ovf_q <= 1'b0;
        end else if (accept && (state_q == SYNC || I_SYNC)) begin
            ovf_q <= (state_q == SYNC) && !I_SYNC && ovf_d;
        end
    end
`endif

endmodule
